// File: rtl/scrod_ack_conditioner.sv
// scrod_ack_conditioner
// Conditions NCH asynchronous SCROD ACK lines for the trigger coincidence
// stage: 2-FF synchroniser, rising-edge detect, programmable stretch window,
// stuck-high auto-mask and per-channel edge counters with registered readback.
// Build option: define ACK_STUCK_DET_EN to build the stuck-high detector.
// Without it STUCK is tied low and STUCK_LIMIT / STUCK_CLR have no effect.
module scrod_ack_conditioner #(
   parameter int NCH   = 12,
   parameter int CNT_W = 16
) (
   input  logic             CLK_42MHZ,
   input  logic             RESET_N,
   input  logic [NCH-1:0]   ACK_IN,
   input  logic [3:0]       WINDOW,
   input  logic [15:0]      STUCK_LIMIT,
   input  logic             STUCK_CLR,
   input  logic             CNT_CLR,
   input  logic [3:0]       CNT_SEL,
   output logic [NCH-1:0]   ACK_OUT,
   output logic [NCH-1:0]   STUCK,
   output logic [CNT_W-1:0] EDGE_COUNT
);

   logic [NCH-1:0]   s1, s2, s3;
   logic [NCH-1:0]   rise;
   logic [NCH-1:0]   kill;       // close the window and hold ACK_OUT low
   logic [3:0]       win [NCH];
   logic [CNT_W-1:0] cnt [NCH];
   logic [CNT_W-1:0] sel_cnt;
   logic [3:0]       win_load;

   // A window of 0 behaves as 1; the counter holds (length - 1)
   assign win_load = (WINDOW == 4'd0) ? 4'd0 : WINDOW - 4'd1;
   assign rise     = s2 & ~s3 & ~STUCK;

   // Two-flop synchroniser plus one history stage for edge detection
   always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= ACK_IN;
         s2 <= s1;
         s3 <= s2;
      end
   end

`ifdef ACK_STUCK_DET_EN
   logic [15:0]    hi [NCH];
   logic [NCH-1:0] stuck_q;
   logic [NCH-1:0] stuck_set;

   // Flag on the edge where s2 completes STUCK_LIMIT consecutive high cycles;
   // a same-cycle STUCK_CLR wins over the set
   always_comb begin
      stuck_set = '0;
      for (int i = 0; i < NCH; i++) begin
         stuck_set[i] = (STUCK_LIMIT != 16'd0) && s2[i] &&
                        (hi[i] == STUCK_LIMIT - 16'd1) && !STUCK_CLR;
      end
   end

   // High-time counters (saturating) and sticky stuck flags
   always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         stuck_q <= '0;
         for (int i = 0; i < NCH; i++) hi[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (STUCK_CLR) begin
               hi[i]      <= '0;
               stuck_q[i] <= 1'b0;
            end else begin
               if (!s2[i])                hi[i] <= '0;
               else if (hi[i] != 16'hFFFF) hi[i] <= hi[i] + 16'd1;
               if (stuck_set[i])          stuck_q[i] <= 1'b1;
            end
         end
      end
   end

   assign STUCK = stuck_q;
   assign kill  = stuck_set | stuck_q;
`else
   logic unused_stuck_cfg;
   assign unused_stuck_cfg = ^{STUCK_LIMIT, STUCK_CLR};
   assign STUCK            = '0;
   assign kill             = '0;
`endif

   // Stretch window: reload on rise (extends an open window), count down,
   // drop ACK_OUT once the counter has reached zero
   always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         ACK_OUT <= '0;
         for (int i = 0; i < NCH; i++) win[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (kill[i]) begin
               ACK_OUT[i] <= 1'b0;
               win[i]     <= '0;
            end else if (rise[i]) begin
               ACK_OUT[i] <= 1'b1;
               win[i]     <= win_load;
            end else if (win[i] != 4'd0) begin
               win[i]     <= win[i] - 4'd1;
            end else begin
               ACK_OUT[i] <= 1'b0;
            end
         end
      end
   end

   // Per-channel edge counters; clear has priority and counters wrap
   always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (CNT_CLR)      cnt[i] <= '0;
            else if (rise[i]) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // Select the addressed counter; selects past the last channel read zero
   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         if (CNT_SEL == 4'(i)) sel_cnt = cnt[i];
      end
   end

   // Registered readback
   always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
      if (!RESET_N) EDGE_COUNT <= '0;
      else          EDGE_COUNT <= sel_cnt;
   end

endmodule

// File: doc/scrod_ack_conditioner.md
# scrod_ack_conditioner

- Conditions the 12 asynchronous per-SCROD ACK lines before they reach the trigger coincidence logic.
- Per channel: synchronises the line, extracts rising edges, and stretches each edge into a programmable coincidence window.
- Also auto-masks channels stuck high and keeps per-channel 16-bit edge counters for run statistics.
- `ACK_OUT` drives the coincidence stage's `ACK` input directly.

## Interface

Parameters:
- `NCH`, 12, number of SCROD channels
- `CNT_W`, 16, edge-counter width

Ports:
- `CLK_42MHZ` in 1: system clock.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `ACK_IN` in NCH: raw ACK lines, asynchronous to `CLK_42MHZ`.
- `WINDOW` in 4: stretch length in cycles; 0 is treated as 1.
- `STUCK_LIMIT` in 16: consecutive high cycles that flag a channel as stuck; 0 disables detection.
- `STUCK_CLR` in 1: synchronous pulse; clears all stuck flags.
- `CNT_CLR` in 1: synchronous pulse; clears all edge counters.
- `CNT_SEL` in 4: edge-counter read select.
- `ACK_OUT` out NCH: stretched ACK to the coincidence stage.
- `STUCK` out NCH: sticky stuck-high flags.
- `EDGE_COUNT` out CNT_W: registered readback of counter `CNT_SEL`.

## Operation

Reset (`RESET_N` low, asynchronous) clears all state:
- All registers, `ACK_OUT`, `STUCK` and `EDGE_COUNT` are 0.
- Reset mid-window drops `ACK_OUT` immediately, without waiting for a clock edge.

Per channel i:
- **Synchroniser:** 2-FF `s1`→`s2`, then history bit `s3`. `rise = s2 & ~s3 & ~STUCK[i]`.
- **Stretcher:**
  - 4-bit down-counter `win`. `ACK_OUT[i]` is a registered bit.
  - On `rise`: load `win = max(WINDOW,1) - 1` and set `ACK_OUT[i] = 1`.
  - Otherwise: if `win != 0`, decrement; else clear `ACK_OUT[i]`.
  - A `rise` while the window is open reloads the counter, extending the window. Only the latest window length applies.
  - `WINDOW` is sampled only at load. Changing it mid-window does not affect the current window.
- **Stuck detector:**
  - 16-bit counter `hi` increments each cycle `s2 = 1`, saturating at 0xFFFF. It resets to 0 when `s2 = 0`.
  - When `STUCK_LIMIT != 0`, `s2 = 1` and `hi == STUCK_LIMIT - 1`, set `STUCK[i]`. On that same edge, clear `ACK_OUT[i]` and `win`.
  - While `STUCK[i]`: `ACK_OUT[i]` is held 0 and edges are not counted.
  - `STUCK_CLR` clears all flags and all `hi` counters. It has priority over a same-cycle set.
  - After clear, a still-high line produces no `rise` (because `s3 = 1`) until it drops and rises again. It can re-flag after another `STUCK_LIMIT` cycles.
- **Edge counter:**
  - One `CNT_W`-bit counter per channel, incremented on `rise`.
  - Wraps 0xFFFF → 0x0000.
  - `CNT_CLR` has priority over a same-cycle increment; the counter reads 0.
- **Readback:** `EDGE_COUNT` is registered from counter `CNT_SEL`. `CNT_SEL >= NCH` reads 0.

## Timing

- **`ACK_IN` to `ACK_OUT`:** `ACK_IN` first sampled high at edge E0. Then `s2 = 1` after E1, `rise` is valid during E1–E2, and `ACK_OUT` goes high after E2. Latency is 2–3 cycles from the async input transition.
- **Window length:** `ACK_OUT` stays high exactly `max(WINDOW,1)` cycles after the last `rise`, independent of how long `ACK_IN` stays high.
- **Minimum pulse:** one cycle is the minimum detectable `ACK_IN` high pulse. Shorter pulses may be missed.
- **Stuck flag:** `STUCK[i]` rises on the edge where `s2` has been high for `STUCK_LIMIT` consecutive edges. `ACK_OUT[i]` is 0 from that edge on.
- **Readback:** `EDGE_COUNT` reflects a count or select change one cycle later.
- **Simultaneous events:** all channels are independent. Any subset may rise on the same edge; each is counted.

## Configuration

Macro `ACK_STUCK_DET_EN` controls the stuck detector.
- **Defined:** stuck detector built as described.
- **Undefined:**
  - `hi` counters and flags are omitted and `STUCK` is tied to 0.
  - `STUCK_LIMIT` and `STUCK_CLR` are ignored.
  - A held-high line yields one window per rising edge only.

## Test plan

1. **Reset:** `RESET_N` low with `ACK_IN = 0xFFF` → all outputs 0. Release → `ACK_OUT = 0xFFF` 3 cycles later for `WINDOW` cycles.
2. **Basic stretch:** `WINDOW = 5`, single 1-cycle pulse on ch3 → `ACK_OUT[3]` high exactly 5 cycles, 2–3 cycles after the pulse. `CNT_SEL = 3` → `EDGE_COUNT = 1`.
3. **Retrigger:** `WINDOW = 4`, pulses on ch0 at t and t+2 → `ACK_OUT[0]` high continuously for 6 cycles. Count = 2.
4. **Stuck (macro defined):** `STUCK_LIMIT = 100`, ch7 held high → `STUCK = 0x080` after 100 high cycles and `ACK_OUT[7]` is 0.
   - Pulse `STUCK_CLR` with the line still high → flag clears and `ACK_OUT[7]` stays 0. Flag re-sets after 100 more cycles.
   - Drop the line, then pulse it → one normal window.
5. **Wrap and clear:** ch11 counter at 0xFFFF, then one pulse → `EDGE_COUNT = 0x0000`. `CNT_CLR` on the same cycle as a `rise` → reads 0. `CNT_SEL = 13` → reads 0.
6. **Async reset mid-window:** `WINDOW = 15`, `RESET_N` low 3 cycles into the window → `ACK_OUT` 0 immediately and all counters 0.
